// File: rtl/fetch_pc_sequencer.sv
// fetch_pc_sequencer
//   Fetch-stage program counter sequencer. It issues sequential fetch
//   addresses (PC += 4), holds the PC on stalls, waits out unresolved
//   branches and GPU stalls, and redirects to resolved branch targets.
//   All state updates happen on the falling edge of I_CLOCK.
//
// Ports
//   I_CLOCK             clock; state updates on the falling edge
//   I_RESET             asynchronous active-high reset
//   I_LOCK              pipeline enable; 0 holds the sequencer in IDLE
//   I_BranchStallSignal unresolved branch in decode
//   I_DepStallSignal    register dependency in decode
//   I_GPUStallSignal    GPU stage stalling the pipeline
//   I_BranchAddrSelect  branch taken, target resolved (one-cycle pulse)
//   I_BranchPC[15:0]    resolved branch target
//   O_PC[15:0]          fetch address to instruction memory
//   O_FE_Valid          O_PC is a live fetch address this cycle
//   O_State[2:0]        registered FSM state
//   O_StallCount[7:0]   saturating count of stalled cycles
module fetch_pc_sequencer (
  input  logic        I_CLOCK,
  input  logic        I_RESET,
  input  logic        I_LOCK,
  input  logic        I_BranchStallSignal,
  input  logic        I_DepStallSignal,
  input  logic        I_GPUStallSignal,
  input  logic        I_BranchAddrSelect,
  input  logic [15:0] I_BranchPC,
  output logic [15:0] O_PC,
  output logic        O_FE_Valid,
  output logic [2:0]  O_State,
  output logic [7:0]  O_StallCount
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RUN      = 3'd1;
  localparam logic [2:0] S_BR_WAIT  = 3'd2;
  localparam logic [2:0] S_GPU_WAIT = 3'd3;
  localparam logic [2:0] S_REDIRECT = 3'd4;

  logic [2:0]  r_state;
  logic [15:0] r_pc;
  logic        r_valid;
  logic [7:0]  r_stall_cnt;

  logic [2:0]  w_state;
  logic [15:0] w_pc;
  logic        w_valid;
  logic        w_stall;

  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_valid = r_valid;
    if (!I_LOCK) begin
      w_state = S_IDLE;
      w_pc    = '0;
      w_valid = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Branch target pulses are ignored here; the first fetch is PC 0.
          w_state = S_RUN;
          w_pc    = '0;
          w_valid = 1'b1;
        end
        S_RUN, S_BR_WAIT, S_GPU_WAIT, S_REDIRECT: begin
          if (I_BranchAddrSelect) begin
            w_state = S_REDIRECT;
            w_pc    = I_BranchPC;
            w_valid = 1'b0;
          end else if (r_state == S_REDIRECT) begin
            // Target address was loaded last edge; issue it now.
            w_state = S_RUN;
            w_valid = 1'b1;
          end else if (I_GPUStallSignal) begin
            w_state = S_GPU_WAIT;
            w_valid = 1'b0;
          end else if (I_BranchStallSignal) begin
            w_state = S_BR_WAIT;
            w_valid = 1'b0;
          end else if (r_state != S_RUN) begin
            // Leaving a wait state: resume fetch at the held PC.
            w_state = S_RUN;
            w_valid = 1'b1;
          end else if (I_DepStallSignal) begin
            w_valid = 1'b1;
          end else begin
            w_pc    = r_pc + 16'd4;
            w_valid = 1'b1;
          end
        end
        default: begin
          w_state = S_IDLE;
          w_pc    = '0;
          w_valid = 1'b0;
        end
      endcase
    end
  end

  // A cycle is stalled when nothing new is issued: either no valid fetch
  // next cycle, or the same address is presented again.
  assign w_stall = I_LOCK && (r_state != S_IDLE) && (!w_valid || (w_pc == r_pc));

  always_ff @(negedge I_CLOCK or posedge I_RESET) begin
    if (I_RESET) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_valid     <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state <= w_state;
      r_pc    <= w_pc;
      r_valid <= w_valid;
      if (w_stall && (r_stall_cnt != 8'hFF))
        r_stall_cnt <= r_stall_cnt + 8'd1;
    end
  end

  assign O_PC         = r_pc;
  assign O_FE_Valid   = r_valid;
  assign O_State      = r_state;
  assign O_StallCount = r_stall_cnt;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
module tb_fetch_pc_sequencer;

  logic        I_CLOCK;
  logic        I_RESET;
  logic        I_LOCK;
  logic        I_BranchStallSignal;
  logic        I_DepStallSignal;
  logic        I_GPUStallSignal;
  logic        I_BranchAddrSelect;
  logic [15:0] I_BranchPC;
  logic [15:0] O_PC;
  logic        O_FE_Valid;
  logic [2:0]  O_State;
  logic [7:0]  O_StallCount;

  fetch_pc_sequencer dut (
    .I_CLOCK             (I_CLOCK),
    .I_RESET             (I_RESET),
    .I_LOCK              (I_LOCK),
    .I_BranchStallSignal (I_BranchStallSignal),
    .I_DepStallSignal    (I_DepStallSignal),
    .I_GPUStallSignal    (I_GPUStallSignal),
    .I_BranchAddrSelect  (I_BranchAddrSelect),
    .I_BranchPC          (I_BranchPC),
    .O_PC                (O_PC),
    .O_FE_Valid          (O_FE_Valid),
    .O_State             (O_State),
    .O_StallCount        (O_StallCount)
  );

  initial I_CLOCK = 1'b0;
  always #5 I_CLOCK = ~I_CLOCK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: named modes and plain integer arithmetic.
  int unsigned m_mode;   // 0 idle,1 run,2 branch wait,3 gpu wait,4 redirect
  int unsigned m_pc;
  bit          m_valid;
  int unsigned m_stalls;

  function automatic void model_reset();
    m_mode = 0; m_pc = 0; m_valid = 0; m_stalls = 0;
  endfunction

  function automatic void model_edge(bit lk, bit br, bit dep, bit gpu, bit bas, int unsigned bpc);
    int unsigned nm, npc;
    bit nv;
    if (!lk) begin
      m_mode = 0; m_pc = 0; m_valid = 0;
      return;
    end
    nm = m_mode; npc = m_pc; nv = 1;
    if (m_mode == 0) begin
      nm = 1; npc = 0; nv = 1;
    end else if (bas) begin
      nm = 4; npc = bpc; nv = 0;
    end else if (m_mode == 4) begin
      nm = 1; nv = 1;
    end else if (gpu) begin
      nm = 3; nv = 0;
    end else if (br) begin
      nm = 2; nv = 0;
    end else if (m_mode == 1 && !dep) begin
      npc = (m_pc + 4) % 65536;
    end else begin
      nm = 1;
    end
    if (m_mode != 0 && (!nv || npc == m_pc) && m_stalls < 255) m_stalls++;
    m_mode = nm; m_pc = npc; m_valid = nv;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".pc"},    O_PC,                m_pc[15:0]);
    chk({tag, ".valid"}, {15'd0, O_FE_Valid}, {15'd0, m_valid});
    chk({tag, ".state"}, {13'd0, O_State},    m_mode[15:0]);
    chk({tag, ".stall"}, {8'd0, O_StallCount}, m_stalls[15:0]);
  endtask

  // Called just after a rising edge; drives inputs, lets the falling edge
  // update the DUT, then samples after the next rising edge.
  task automatic step(input bit lk, input bit br, input bit dep, input bit gpu,
                      input bit bas, input logic [15:0] bpc, input string tag);
    I_LOCK = lk; I_BranchStallSignal = br; I_DepStallSignal = dep;
    I_GPUStallSignal = gpu; I_BranchAddrSelect = bas; I_BranchPC = bpc;
    @(negedge I_CLOCK);
    model_edge(lk, br, dep, gpu, bas, {16'd0, bpc});
    @(posedge I_CLOCK);
    #1;
    check_model(tag);
  endtask

  // Reset pulse placed between falling edges; outputs must clear at once.
  task automatic reset_pulse(input string tag);
    #1 I_RESET = 1'b1;
    #1;
    chk({tag, ".rst_pc"},    O_PC,                16'h0000);
    chk({tag, ".rst_valid"}, {15'd0, O_FE_Valid}, 16'd0);
    chk({tag, ".rst_state"}, {13'd0, O_State},    16'd0);
    chk({tag, ".rst_stall"}, {8'd0, O_StallCount}, 16'd0);
    #1 I_RESET = 1'b0;
    model_reset();
  endtask

  initial begin
    I_RESET = 1'b1; I_LOCK = 0; I_BranchStallSignal = 0; I_DepStallSignal = 0;
    I_GPUStallSignal = 0; I_BranchAddrSelect = 0; I_BranchPC = '0;
    model_reset();
    repeat (2) @(posedge I_CLOCK);
    #1;
    chk("reset.pc",    O_PC,                16'h0000);
    chk("reset.valid", {15'd0, O_FE_Valid}, 16'd0);
    chk("reset.state", {13'd0, O_State},    16'd0);
    chk("reset.stall", {8'd0, O_StallCount}, 16'd0);
    I_RESET = 1'b0;

    // Sequential fetch after lock
    step(1,0,0,0,0,0,"seq0"); chk("seq0.const", O_PC, 16'h0000);
    chk("seq0.valid", {15'd0, O_FE_Valid}, 16'd1);
    step(1,0,0,0,0,0,"seq1"); chk("seq1.const", O_PC, 16'h0004);
    step(1,0,0,0,0,0,"seq2"); chk("seq2.const", O_PC, 16'h0008);
    step(1,0,0,0,0,0,"seq3"); chk("seq3.const", O_PC, 16'h000C);
    chk("seq3.state", {13'd0, O_State}, 16'd1);

    // Dependency stall holds PC but stays valid
    step(1,0,0,0,0,0,"dep_pre"); chk("dep_pre.const", O_PC, 16'h0010);
    repeat (3) step(1,0,1,0,0,0,"dep");
    chk("dep.pc",    O_PC, 16'h0010);
    chk("dep.valid", {15'd0, O_FE_Valid}, 16'd1);
    chk("dep.cnt",   {8'd0, O_StallCount}, 16'd3);
    step(1,0,0,0,0,0,"dep_post"); chk("dep_post.const", O_PC, 16'h0014);

    // Branch wait then redirect
    repeat (3) step(1,0,0,0,0,0,"to20");
    chk("to20.const", O_PC, 16'h0020);
    repeat (2) step(1,1,0,0,0,0,"brw");
    chk("brw.state", {13'd0, O_State}, 16'd2);
    chk("brw.valid", {15'd0, O_FE_Valid}, 16'd0);
    step(1,1,0,0,1,16'h0100,"redir");
    chk("redir.state", {13'd0, O_State}, 16'd4);
    chk("redir.pc", O_PC, 16'h0100);
    step(1,0,0,0,0,0,"tgt");
    chk("tgt.state", {13'd0, O_State}, 16'd1);
    chk("tgt.valid", {15'd0, O_FE_Valid}, 16'd1);
    step(1,0,0,0,0,0,"tgt4"); chk("tgt4.const", O_PC, 16'h0104);

    // GPU stall over an unresolved branch
    step(1,1,0,1,0,0,"gpu");   chk("gpu.state", {13'd0, O_State}, 16'd3);
    step(1,1,0,0,0,0,"gpu_br"); chk("gpu_br.state", {13'd0, O_State}, 16'd2);
    step(1,0,0,0,0,0,"gpu_run"); chk("gpu_run.state", {13'd0, O_State}, 16'd1);
    chk("gpu_run.pc", O_PC, 16'h0104);

    // Wrap and stall-count saturation
    step(1,0,0,0,1,16'hFFF8,"wrapA");
    step(1,0,0,0,0,0,"wrapB");
    step(1,0,0,0,0,0,"wrapC"); chk("wrapC.const", O_PC, 16'hFFFC);
    step(1,0,0,0,0,0,"wrapD"); chk("wrapD.const", O_PC, 16'h0000);
    repeat (300) step(1,0,0,1,0,0,"sat");
    chk("sat.const", {8'd0, O_StallCount}, 16'd255);
    step(0,0,0,0,0,0,"unlock");
    chk("unlock.cnt", {8'd0, O_StallCount}, 16'd255);

    // Reset while redirecting discards the target
    step(1,0,0,0,0,0,"re_idle");
    step(1,0,0,0,1,16'h0200,"re_redir");
    chk("re_redir.state", {13'd0, O_State}, 16'd4);
    reset_pulse("midrst");
    step(1,0,0,0,0,0,"after_rst");
    chk("after_rst.const", O_PC, 16'h0000);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) reset_pulse("rnd");
      step($urandom_range(0, 99) >= 3,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 12,
           $urandom_range(0, 99) < 6,
           16'($urandom),
           "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
